alu_control_seq: RTL and testbench
==================================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter BITS_PER_CYCLE (BPC), default 1, multiplier bits retired per cycle; DATA_W % BPC == 0.
REQ-003 SHALL derive N = DATA_W/BPC (multiply iterations) and CNT_W = max(1, clog2(N)).
REQ-004 Ports: clk  in  1  sole clock, rising edge.
REQ-005 Ports: rst  in  1  synchronous active-high reset.
REQ-006 Ports: nop  in  1  bubble in EX; forces decode outputs idle.
REQ-007 Ports: alu_op  in  2  main-control ALU class.
REQ-008 Ports: funct  in  6  R-type function field.
REQ-009 Ports: src_a, src_b  in  DATA_W each  MULTU operands.
REQ-010 Ports: operation  out  3  ALU opcode.
REQ-011 Ports: mux_sel  out  2  result select (00 ALU, 01 HI, 10 LO, 11 shifter).
REQ-012 Ports: sht_en, jr, illegal  out  1 each  shifter enable, jump-register, undefined funct.
REQ-013 Ports: stall  out  1  freeze IF/ID/EX while multiply pending.
REQ-014 Ports: hi, lo  out  DATA_W each  architectural HI/LO registers.
REQ-015 Ports: mul_done  out  1  one-cycle pulse, HI/LO just written.

Function
REQ-016 Decode SHALL be combinational from nop/alu_op/funct; nop=1 or rst=1 forces operation=000, mux_sel=00, sht_en=jr=illegal=0.
REQ-017 alu_op 00->010, 01->110, 11->000; alu_op=10 uses funct.
REQ-018 funct table: 36->000, 37->001, 32->010, 34->110, 42->111, 0->sht_en=1,mux_sel=11, 16->mux_sel=01, 18->mux_sel=10, 8->operation=010,jr=1, 25 (MULTU)->operation=000.
REQ-019 Any other funct under alu_op=10 SHALL give operation=000, illegal=1; never X.
REQ-020 FSM states IDLE, MUL; issue = IDLE & !nop & alu_op=10 & funct=25 & !mul_done.
REQ-021 On issue edge: latch src_a/src_b, clear 2*DATA_W accumulator, cnt=0, go MUL.
REQ-022 MUL: each cycle add (multiplicand << cnt*BPC) x next BPC multiplier bits, unsigned; cnt++.
REQ-023 At edge with cnt=N-1: {hi,lo} <= full 2*DATA_W product, state->IDLE, mul_done<=1 for exactly one cycle.
REQ-024 stall SHALL be combinational: 1 when issue or state=MUL; total stall = N+1 cycles.
REQ-025 mul_done=1 SHALL suppress re-issue of the still-held MULTU that cycle (back-to-back MULTU issues on the following cycle).
REQ-026 nop, alu_op, funct changes during MUL SHALL not affect the multiply; decode outputs still track inputs.
REQ-027 MFHI/MFLO in IDLE read registered hi/lo; in mul_done cycle they see the new product.
REQ-028 hi/lo SHALL change only at multiply completion or reset.

Reset
REQ-029 rst SHALL win over every other event, including the completion edge.
REQ-030 On rst: state=IDLE, cnt=0, accumulator=0, hi=lo=0, mul_done=0, stall=0 next cycle; in-flight multiply discarded.

Structure
REQ-031 Package alu_ctrl_pkg SHALL hold funct codes, alu_op encodings, operation codes, mux_sel codes, FSM state enum.
REQ-032 Iterative datapath (operand latches, accumulator, counter) SHALL be sub-module multu_iter; decode and FSM stay in top.

Verification
REQ-033 DATA_W=32,BPC=1: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, mul_done one pulse.
REQ-034 BPC=4: MULTU 0x00012345 x 0x00010000 -> stall 9 cycles, hi=0x00000001, lo=0x23450000.
REQ-035 Decode sweep: alu_op=10 funct 32/34/42/8/0/16/18/51 -> 010/110/111/010+jr/sht_en+11/01/10/illegal=1,op=000; nop=1 zeroes all.
REQ-036 rst asserted mid-MUL (cnt=10) -> next cycle stall=0, hi=lo=0, no mul_done pulse.
REQ-037 Two MULTU back-to-back (3x5 then 7x9) -> exactly two mul_done pulses, final lo=63, hi=0; MFHI after first reads 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control block: funct codes, alu_op classes, opcodes, result mux selects, FSM states.
// No logic; pure constants and types.
// Not applicable (no handshake).
package alu_ctrl_pkg;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_HI  = 2'b01;
    localparam logic [1:0] MUX_LO  = 2'b10;
    localparam logic [1:0] MUX_SHT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multu_iter.sv
// Iterative unsigned shift-add multiplier: operand latches, 2*DATA_W accumulator, iteration counter.
// Latency: DATA_W/BPC run cycles after start; product is valid combinationally while last is high.
// No backpressure: the owner holds run high until last.
module multu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BPC    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  run,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    output logic                  last,
    output logic [2*DATA_W-1:0]   product
);
    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = cnt_width(N);
    localparam int PW    = 2 * DATA_W;

    if (DATA_W % BPC != 0) begin : g_bad_bpc
        $error("DATA_W must be a multiple of BITS_PER_CYCLE");
    end

    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     partial;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;

    // mcand is pre-shifted by cnt*BPC and mplier pre-shifted right, so the low BPC bits are the current digit
    assign partial = mcand * {{(PW-BPC){1'b0}}, mplier[BPC-1:0]};
    assign product = acc + partial;
    assign last    = run && (cnt == CNT_W'(N-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{DATA_W{1'b0}}, src_a};
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control decode plus sequencer for an iterative MULTU writing HI/LO.
// Decode is combinational; MULTU stalls the pipe for N+1 cycles, HI/LO written at completion.
// Backpressure: stall freezes IF/ID/EX while the multiply is pending.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nop,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [2:0]        operation,
    output logic [1:0]        mux_sel,
    output logic              sht_en,
    output logic              jr,
    output logic              illegal,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              mul_done
);
    state_t              state, state_nxt;
    logic                issue;
    logic                mul_run;
    logic                last;
    logic [2*DATA_W-1:0] product;

    // mul_done blocks the still-held MULTU from re-issuing in its completion cycle
    assign issue   = !rst && (state == ST_IDLE) && !nop && (alu_op == ALUOP_RTYPE)
                     && (funct == FN_MULTU) && !mul_done;
    assign mul_run = (state == ST_MUL);
    assign stall   = issue || mul_run;

    multu_iter #(
        .DATA_W (DATA_W),
        .BPC    (BITS_PER_CYCLE)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (issue),
        .run     (mul_run),
        .src_a   (src_a),
        .src_b   (src_b),
        .last    (last),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_MUL;
            ST_MUL:  if (last)  state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            mul_done <= 1'b0;
        end else begin
            mul_done <= last;
            if (last) {hi, lo} <= product;
        end
    end

    always_comb begin
        operation = OP_AND;
        mux_sel   = MUX_ALU;
        sht_en    = 1'b0;
        jr        = 1'b0;
        illegal   = 1'b0;
        if (!(nop || rst)) begin
            case (alu_op)
                ALUOP_ADD:   operation = OP_ADD;
                ALUOP_SUB:   operation = OP_SUB;
                ALUOP_AND:   operation = OP_AND;
                default: begin
                    case (funct)
                        FN_AND:   operation = OP_AND;
                        FN_OR:    operation = OP_OR;
                        FN_ADD:   operation = OP_ADD;
                        FN_SUB:   operation = OP_SUB;
                        FN_SLT:   operation = OP_SLT;
                        FN_SLL: begin
                            sht_en  = 1'b1;
                            mux_sel = MUX_SHT;
                        end
                        FN_MFHI:  mux_sel = MUX_HI;
                        FN_MFLO:  mux_sel = MUX_LO;
                        FN_JR: begin
                            operation = OP_ADD;
                            jr        = 1'b1;
                        end
                        FN_MULTU: operation = OP_AND;
                        default:  illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, MULTU timing and results at BPC=1 and BPC=4, reset mid-multiply.
module tb_alu_control_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        nop;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [2:0]  operation;
    logic [1:0]  mux_sel;
    logic        sht_en, jr, illegal, stall, mul_done;
    logic [31:0] hi, lo;

    logic        nop_4;
    logic [1:0]  alu_op_4;
    logic [5:0]  funct_4;
    logic [31:0] src_a_4, src_b_4;
    logic [2:0]  operation_4;
    logic [1:0]  mux_sel_4;
    logic        sht_en_4, jr_4, illegal_4, stall_4, mul_done_4;
    logic [31:0] hi_4, lo_4;

    logic [7:0]  dec;
    assign dec = {operation, mux_sel, sht_en, jr, illegal};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control_seq #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .nop(nop), .alu_op(alu_op), .funct(funct),
        .src_a(src_a), .src_b(src_b), .operation(operation), .mux_sel(mux_sel),
        .sht_en(sht_en), .jr(jr), .illegal(illegal), .stall(stall),
        .hi(hi), .lo(lo), .mul_done(mul_done)
    );

    alu_control_seq #(.DATA_W(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .nop(nop_4), .alu_op(alu_op_4), .funct(funct_4),
        .src_a(src_a_4), .src_b(src_b_4), .operation(operation_4), .mux_sel(mux_sel_4),
        .sht_en(sht_en_4), .jr(jr_4), .illegal(illegal_4), .stall(stall_4),
        .hi(hi_4), .lo(lo_4), .mul_done(mul_done_4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       nop;
        logic [1:0] op;
        logic [5:0] fn;
        logic [7:0] exp;
    } dvec_t;

    dvec_t tbl[15];

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit chain,
                           input logic [31:0] a2, input logic [31:0] b2,
                           output int stalls, output int dones);
        logic [63:0] p;
        p      = {32'd0, a} * {32'd0, b};
        nop    = 1'b0;
        alu_op = 2'b10;
        funct  = 6'd25;
        src_a  = a;
        src_b  = b;
        stalls = 0;
        dones  = 0;
        for (int i = 0; i < 120; i++) begin
            #1;
            if (stall) stalls++;
            if (i == 5) begin
                chk("multu_decode", 64'(dec), 64'h00);
                alu_op = 2'b00;
                #1;
                chk("decode_tracks_in_mul", 64'(dec), 64'b010_00_000);
                alu_op = 2'b10;
            end
            if (mul_done) begin
                dones++;
                if (chain && dones == 1) begin
                    chk("mfhi_after_first", 64'(hi), {32'd0, p[63:32]});
                    chk("mflo_after_first", 64'(lo), {32'd0, p[31:0]});
                    src_a = a2;
                    src_b = b2;
                end else begin
                    alu_op = 2'b00;
                    funct  = 6'd0;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int stalls, dones;

        rst = 1'b1; nop = 1'b0; alu_op = 2'b00; funct = 6'd0; src_a = '0; src_b = '0;
        nop_4 = 1'b0; alu_op_4 = 2'b00; funct_4 = 6'd0; src_a_4 = '0; src_b_4 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_decode_idle", 64'(dec), 64'h00);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_mul_done", 64'(mul_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl[0]  = '{1'b0, 2'b00, 6'd37, 8'b010_00_000};
        tbl[1]  = '{1'b0, 2'b01, 6'd0,  8'b110_00_000};
        tbl[2]  = '{1'b0, 2'b11, 6'd8,  8'b000_00_000};
        tbl[3]  = '{1'b0, 2'b10, 6'd36, 8'b000_00_000};
        tbl[4]  = '{1'b0, 2'b10, 6'd37, 8'b001_00_000};
        tbl[5]  = '{1'b0, 2'b10, 6'd32, 8'b010_00_000};
        tbl[6]  = '{1'b0, 2'b10, 6'd34, 8'b110_00_000};
        tbl[7]  = '{1'b0, 2'b10, 6'd42, 8'b111_00_000};
        tbl[8]  = '{1'b0, 2'b10, 6'd8,  8'b010_00_010};
        tbl[9]  = '{1'b0, 2'b10, 6'd0,  8'b000_11_100};
        tbl[10] = '{1'b0, 2'b10, 6'd16, 8'b000_01_000};
        tbl[11] = '{1'b0, 2'b10, 6'd18, 8'b000_10_000};
        tbl[12] = '{1'b0, 2'b10, 6'd51, 8'b000_00_001};
        tbl[13] = '{1'b1, 2'b10, 6'd0,  8'b000_00_000};
        tbl[14] = '{1'b1, 2'b10, 6'd51, 8'b000_00_000};
        for (int i = 0; i < 15; i++) begin
            nop = tbl[i].nop; alu_op = tbl[i].op; funct = tbl[i].fn;
            #1;
            chk($sformatf("decode_%0d_fn%0d", i, tbl[i].fn), 64'(dec), 64'(tbl[i].exp));
            chk($sformatf("decode_%0d_stall", i), 64'(stall), 64'd0);
            @(negedge clk);
        end

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, stalls, dones);
        chk("max_stall_cycles", 64'(stalls), 64'd33);
        chk("max_done_pulses", 64'(dones), 64'd1);
        chk("max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("max_lo", 64'(lo), 64'h0000_0001);

        run_mul(32'd3, 32'd5, 1'b1, 32'd7, 32'd9, stalls, dones);
        chk("b2b_stall_cycles", 64'(stalls), 64'd66);
        chk("b2b_done_pulses", 64'(dones), 64'd2);
        chk("b2b_hi", 64'(hi), 64'd0);
        chk("b2b_lo", 64'(lo), 64'd63);

        nop_4 = 1'b0; alu_op_4 = 2'b10; funct_4 = 6'd25;
        src_a_4 = 32'h0001_2345; src_b_4 = 32'h0001_0000;
        stalls = 0; dones = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (stall_4) stalls++;
            if (mul_done_4) begin
                dones++;
                alu_op_4 = 2'b00; funct_4 = 6'd0;
            end
            @(negedge clk);
        end
        chk("bpc4_stall_cycles", 64'(stalls), 64'd9);
        chk("bpc4_done_pulses", 64'(dones), 64'd1);
        chk("bpc4_hi", 64'(hi_4), 64'h0000_0001);
        chk("bpc4_lo", 64'(lo_4), 64'h2345_0000);

        nop = 1'b0; alu_op = 2'b10; funct = 6'd25;
        src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        repeat (11) @(negedge clk);
        rst = 1'b1; funct = 6'd32;
        #1;
        chk("rst_overrides_decode", 64'(dec), 64'h00);
        @(negedge clk);
        #1;
        chk("midmul_rst_stall", 64'(stall), 64'd0);
        chk("midmul_rst_hi", 64'(hi), 64'd0);
        chk("midmul_rst_lo", 64'(lo), 64'd0);
        chk("midmul_rst_done", 64'(mul_done), 64'd0);
        rst = 1'b0; alu_op = 2'b00; funct = 6'd0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (mul_done) dones++;
        end
        chk("midmul_no_pulse", 64'(dones), 64'd0);
        chk("midmul_hi_kept", 64'(hi), 64'd0);
        chk("midmul_lo_kept", 64'(lo), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
